// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory slave for a MIPS core: req/ack handshake with
// WAIT_CYCLES wait states, byte-lane stores, and fault reporting on bad addresses.
module mips_dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int         AW          = $clog2(DEPTH_WORDS);
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT      = 2'd1;
   localparam logic [1:0] S_RESP      = 2'd2;
   localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [31:0] LP_DEPTH   = 32'(DEPTH_WORDS);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_resp;
   logic          w_src_we;
   logic [31:0]   w_src_addr;
   logic [31:0]   w_src_wdata;
   logic [3:0]    w_src_be;
   logic          w_src_fault;
   logic          w_fault;
   logic          w_mem_we;
   logic [AW-1:0] w_src_idx;
   logic [AW-1:0] w_rd_idx;

   assign w_accept     = (r_state == S_IDLE) && req;
   assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd0));
   assign w_resp       = (r_state == S_RESP);

   // With zero wait states the write lands on the accept edge itself, so the
   // request fields come straight from the ports rather than the capture regs.
   assign w_src_we    = (r_state == S_IDLE) ? we      : r_we;
   assign w_src_addr  = (r_state == S_IDLE) ? addr    : r_addr;
   assign w_src_wdata = (r_state == S_IDLE) ? wdata   : r_wdata;
   assign w_src_be    = (r_state == S_IDLE) ? byte_en : r_be;

   assign w_src_fault = (w_src_addr[1:0] != 2'b00) || ({2'b00, w_src_addr[31:2]} >= LP_DEPTH);
   assign w_fault     = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= LP_DEPTH);
   assign w_src_idx   = w_src_addr[AW+1:2];
   assign w_rd_idx    = r_addr[AW+1:2];

   // rst_n gates the write so a store presented while in reset cannot land.
   assign w_mem_we = rst_n && w_enter_resp && w_src_we && !w_src_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_be    <= byte_en;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= LP_CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_src_be[i]) begin
               r_mem[w_src_idx][8*i +: 8] <= w_src_wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      ack   = w_resp;
      err   = w_resp && w_fault;
      rdata = 32'd0;
      if (w_resp && !r_we && !w_fault) begin
         rdata = r_mem[w_rd_idx];
      end
   end

endmodule
